// File: rtl/mem_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_io_bridge_pkg
// Purpose : Shared I/O offsets, STATUS bit positions and address decode.
// Rev     : 1.0  initial release
// ============================================================================
package mem_io_bridge_pkg;

    localparam logic [7:0] IO_OFF_OUT    = 8'd0;
    localparam logic [7:0] IO_OFF_STATUS = 8'd1;
    localparam logic [7:0] IO_OFF_IN     = 8'd2;

    localparam int ST_IN_FULL   = 0;
    localparam int ST_OUT_FULL  = 1;
    localparam int ST_OUT_EMPTY = 2;
    localparam int ST_OVF       = 3;

    typedef enum logic [2:0] {
        RGN_RAM    = 3'd0,
        RGN_OUT    = 3'd1,
        RGN_STATUS = 3'd2,
        RGN_IN     = 3'd3,
        RGN_NONE   = 3'd4
    } region_e;

    function automatic region_e decode_addr(input logic [7:0] a, input logic [7:0] base);
        logic [7:0] off;
        off = a - base;
        if (a < base)
            return RGN_RAM;
        case (off)
            IO_OFF_OUT:    return RGN_OUT;
            IO_OFF_STATUS: return RGN_STATUS;
            IO_OFF_IN:     return RGN_IN;
            default:       return RGN_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with count, full/empty and push-while-full-pop.
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mem_io_bridge
// Purpose : CPU RAM plus memory-mapped output FIFO, input register and STATUS.
// Rev     : 1.0  initial release
// ============================================================================
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IO_BASE    = 8'hF0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata,
    input  logic       ld_en,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);

    localparam int RAM_DEPTH = int'(IO_BASE);
    localparam int CNT_W     = $clog2(FIFO_DEPTH+1);

    logic [7:0] r_ram [RAM_DEPTH];
    logic [7:0] r_in_data;
    logic       r_in_full;
    logic       r_ovf;

    region_e    w_region;
    logic       w_cpu_we;
    logic       w_push_req;
    logic       w_pop;
    logic       w_push_rej;
    logic       w_ack;
    logic       w_capture;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [7:0] w_status;

    assign w_region   = decode_addr(addr, IO_BASE);
    // The loader owns the write port: any CPU write in a loader cycle is dropped.
    assign w_cpu_we   = we && !ld_en;
    assign w_push_req = w_cpu_we && (w_region == RGN_OUT);
    assign w_pop      = out_valid && out_ready;
    assign w_push_rej = w_push_req && !w_pop && (w_fifo_count == CNT_W'(FIFO_DEPTH));
    assign w_ack      = w_cpu_we && (w_region == RGN_IN);
    assign w_capture  = in_valid && !r_in_full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push_req),
        .i_push_data (wdata),
        .i_pop       (w_pop),
        .o_pop_data  (out_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign in_ready  = !r_in_full;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (ld_addr < IO_BASE)
                r_ram[ld_addr] <= ld_data;
        end else if (we && (w_region == RGN_RAM)) begin
            r_ram[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data <= 8'h00;
            r_in_full <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            // Acknowledge wins over a coincident capture.
            if (w_ack) begin
                r_in_full <= 1'b0;
            end else if (w_capture) begin
                r_in_data <= in_data;
                r_in_full <= 1'b1;
            end
            if (w_cpu_we && (w_region == RGN_STATUS))
                r_ovf <= 1'b0;
            else if (w_push_rej)
                r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_status               = 8'h00;
        w_status[ST_IN_FULL]   = r_in_full;
        w_status[ST_OUT_FULL]  = w_fifo_full;
        w_status[ST_OUT_EMPTY] = w_fifo_empty;
        w_status[ST_OVF]       = r_ovf;
    end

    always_comb begin
        rdata = 8'h00;
        case (w_region)
            RGN_RAM:    rdata = r_ram[addr];
            RGN_STATUS: rdata = w_status;
            RGN_IN:     rdata = r_in_data;
            default:    rdata = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_io_bridge
// Purpose : Scoreboard bench for the memory / I/O bridge.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_io_bridge;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] last_pop = 8'h00;
    logic [7:0] sb[$];

    mem_io_bridge #(
        .FIFO_DEPTH (4),
        .IO_BASE    (8'hF0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: score any pop and predict any push at the negedge, return just after posedge.
    task automatic step();
        logic [7:0] exp_v;
        @(negedge clk);
        if (out_valid && out_ready) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL out_unexpected: got %h required no output", out_data);
            end else begin
                exp_v = sb.pop_front();
                if (out_data !== exp_v)
                    $display("FAIL out_data: got %h required %h", out_data, exp_v);
                else
                    pass_cnt++;
                last_pop = out_data;
                pop_cnt++;
            end
        end
        if (we && !ld_en && addr == 8'hF0 && sb.size() < 4)
            sb.push_back(wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        addr = 8'hF1;
        #1;
        total_cnt++;
        if (rdata !== 8'h04) $display("FAIL rst_status: got %h required 04", rdata); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h required 00", out_data); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else pass_cnt++;
        addr = 8'hF2;
        #1;
        total_cnt++;
        if (rdata !== 8'h00) $display("FAIL rst_in_reg: got %h required 00", rdata); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_loader();
        ld_en = 1'b1; ld_addr = 8'h10; ld_data = 8'h42;
        we = 1'b1; addr = 8'h10; wdata = 8'h99;
        step();
        ld_addr = 8'h20; ld_data = 8'h77;
        addr = 8'hF0; wdata = 8'h55;
        step();
        ld_en = 1'b0; we = 1'b0;
        addr = 8'h10;
        #1;
        total_cnt++;
        if (rdata !== 8'h42) $display("FAIL ld_ram10: got %h required 42", rdata); else pass_cnt++;
        addr = 8'h20;
        #1;
        total_cnt++;
        if (rdata !== 8'h77) $display("FAIL ld_ram20: got %h required 77", rdata); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL ld_out_ignored: got %b required 0", out_valid); else pass_cnt++;
        we = 1'b1; addr = 8'h11; wdata = 8'h5A;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (rdata !== 8'h5A) $display("FAIL cpu_ram11: got %h required 5a", rdata); else pass_cnt++;
        addr = 8'hF0;
        #1;
        total_cnt++;
        if (rdata !== 8'h00) $display("FAIL rd_out_zero: got %h required 00", rdata); else pass_cnt++;
        addr = 8'hF7;
        #1;
        total_cnt++;
        if (rdata !== 8'h00) $display("FAIL rd_unmapped: got %h required 00", rdata); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int start_pops;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            we = 1'b1; addr = 8'hF0; wdata = 8'(i);
            step();
        end
        we = 1'b0; addr = 8'hF1;
        #1;
        total_cnt++;
        if (rdata !== 8'h0A) $display("FAIL ovf_status: got %h required 0a", rdata); else pass_cnt++;
        we = 1'b1; wdata = 8'hFF;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (rdata !== 8'h02) $display("FAIL ovf_clear: got %h required 02", rdata); else pass_cnt++;
        start_pops = pop_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++)
            step();
        total_cnt++;
        if (pop_cnt - start_pops != 4 || sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL ovf_drain: got %0d pops required 4", pop_cnt - start_pops);
        else
            pass_cnt++;
        #1;
        total_cnt++;
        if (rdata !== 8'h04) $display("FAIL ovf_drained_status: got %h required 04", rdata); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = 8'hF0; wdata = 8'h11 + 8'(i);
            step();
        end
        we = 1'b0; addr = 8'hF1;
        #1;
        total_cnt++;
        if (rdata !== 8'h02) $display("FAIL fp_full: got %h required 02", rdata); else pass_cnt++;
        we = 1'b1; addr = 8'hF0; wdata = 8'h09; out_ready = 1'b1;
        step();
        we = 1'b0; addr = 8'hF1;
        for (int i = 0; i < 20 && out_valid; i++)
            step();
        total_cnt++;
        if (last_pop !== 8'h09 || sb.size() != 0)
            $display("FAIL fp_last: got %h required 09", last_pop);
        else
            pass_cnt++;
        #1;
        total_cnt++;
        if (rdata !== 8'h04) $display("FAIL fp_no_ovf: got %h required 04", rdata); else pass_cnt++;
    endtask

    task automatic test_in();
        in_data = 8'h7E; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL in_ready_busy: got %b required 0", in_ready); else pass_cnt++;
        addr = 8'hF1;
        #1;
        total_cnt++;
        if (rdata !== 8'h05) $display("FAIL in_status: got %h required 05", rdata); else pass_cnt++;
        addr = 8'hF2;
        #1;
        total_cnt++;
        if (rdata !== 8'h7E) $display("FAIL in_read: got %h required 7e", rdata); else pass_cnt++;
        in_data = 8'h33; in_valid = 1'b1;
        we = 1'b1; wdata = 8'h00;
        step();
        we = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL in_ack: got %b required 1", in_ready); else pass_cnt++;
        total_cnt++;
        if (rdata !== 8'h7E) $display("FAIL in_no_capture: got %h required 7e", rdata); else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (rdata !== 8'h33 || in_ready !== 1'b0)
            $display("FAIL in_capture2: got %h/%b required 33/0", rdata, in_ready);
        else
            pass_cnt++;
        we = 1'b1;
        step();
        we = 1'b0; addr = 8'hF1;
        #1;
        total_cnt++;
        if (rdata !== 8'h04) $display("FAIL in_ack_status: got %h required 04", rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; addr = 8'hF0; wdata = 8'hA1 + 8'(i);
            step();
        end
        we = 1'b0; addr = 8'hF1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1)
            $display("FAIL rm_queued: got %b/%h required 1/a1", out_valid, out_data);
        else
            pass_cnt++;
        rst_n = 1'b0;
        #1;
        sb.delete();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b required 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (rdata !== 8'h04) $display("FAIL rm_status: got %h required 04", rdata); else pass_cnt++;
        addr = 8'h10;
        #1;
        total_cnt++;
        if (rdata !== 8'h42) $display("FAIL rm_ram_kept: got %h required 42", rdata); else pass_cnt++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rm_after: got %b required 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; addr = 8'h00; wdata = 8'h00; we = 1'b0;
        ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
        out_ready = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        test_reset();
        test_loader();
        test_overflow();
        test_full_pop();
        test_in();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
